// File: rtl/muldiv_pkg.sv
// Shared types and sizing helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Width of the iteration counter, which must hold SIZE-1.
  function automatic int cnt_width(input int size);
    return (size < 2) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational conditional two's-complement negate, one independent lane per
// value; each lane is negated when its neg_i bit is set.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int SIZE  = 33,
  parameter int LANES = 1
) (
  input  logic [LANES-1:0][SIZE-1:0] val_i,
  input  logic [LANES-1:0]           neg_i,
  output logic [LANES-1:0][SIZE-1:0] res_o
);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign res_o[gi] = neg_i[gi] ? ({SIZE{1'b0}} - val_i[gi]) : val_i[gi];
    end
  endgenerate

endmodule

// File: rtl/muldiv_nbit.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle.
// Define MULDIV_EARLY_OUT_EN to bypass the iteration for zero operands.
module muldiv_nbit
  import muldiv_pkg::*;
#(
  parameter int SIZE = 33
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                kill,
  input  logic                start,
  input  logic                is_div,
  input  logic                is_signed,
  input  logic [SIZE-1:0]     op_a,
  input  logic [SIZE-1:0]     op_b,
  output logic                ready,
  output logic                valid,
  output logic                error,
  output logic [2*SIZE-1:0]   product,
  output logic [SIZE-1:0]     quotient,
  output logic [SIZE-1:0]     remainder
);

  localparam int CW = cnt_width(SIZE);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SIZE - 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                is_div_q, is_div_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic                bz_q, bz_d;
  logic [SIZE-1:0]     opnd_q, opnd_d;
  logic [2*SIZE-1:0]   acc_q, acc_d;
  logic [SIZE-1:0]     rem_q, rem_d;
  logic [2*SIZE-1:0]   product_q, product_d;
  logic [SIZE-1:0]     quotient_q, quotient_d;
  logic [SIZE-1:0]     remainder_q, remainder_d;
  logic                error_q, error_d;

  logic [1:0][SIZE-1:0]   op_mag;
  logic [0:0][2*SIZE-1:0] prod_fix;
  logic [1:0][SIZE-1:0]   qr_fix;

  logic [SIZE:0]       mul_sum;
  logic [SIZE:0]       div_shift;
  logic [SIZE+1:0]     div_diff;
  logic                div_borrow;

  muldiv_sign_fix #(.SIZE(SIZE), .LANES(2)) u_fix_opnd (
    .val_i ({op_b, op_a}),
    .neg_i ({is_signed & op_b[SIZE-1], is_signed & op_a[SIZE-1]}),
    .res_o (op_mag)
  );

  muldiv_sign_fix #(.SIZE(2*SIZE), .LANES(1)) u_fix_prod (
    .val_i (acc_q),
    .neg_i (sign_a_q ^ sign_b_q),
    .res_o (prod_fix)
  );

  muldiv_sign_fix #(.SIZE(SIZE), .LANES(2)) u_fix_qr (
    .val_i ({rem_q, acc_q[SIZE-1:0]}),
    .neg_i ({sign_a_q, sign_a_q ^ sign_b_q}),
    .res_o (qr_fix)
  );

  // Multiply: acc = {partial sum, remaining multiplier}. Divide: acc[SIZE-1:0]
  // shifts dividend bits out of the top while quotient bits enter at the bottom;
  // div_shift is the SIZE+1-bit partial remainder for this step.
  always_comb begin
    mul_sum    = {1'b0, acc_q[2*SIZE-1:SIZE]} + (acc_q[0] ? {1'b0, opnd_q} : {(SIZE+1){1'b0}});
    div_shift  = {rem_q, acc_q[SIZE-1]};
    div_diff   = {1'b0, div_shift} - {2'b00, opnd_q};
    div_borrow = div_diff[SIZE+1];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    bz_d        = bz_q;
    opnd_d      = opnd_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    product_d   = product_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    error_d     = error_q;

    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          is_div_d = is_div;
          sign_a_d = is_signed & op_a[SIZE-1];
          sign_b_d = is_signed & op_b[SIZE-1];
          bz_d     = (op_b == '0);
          opnd_d   = is_div ? op_mag[1] : op_mag[0];
          acc_d    = {{SIZE{1'b0}}, (is_div ? op_mag[0] : op_mag[1])};
          rem_d    = '0;
          cnt_d    = CNT_LOAD;
          state_d  = CALC;
`ifdef MULDIV_EARLY_OUT_EN
          if (is_div && (op_b == '0)) begin
            state_d     = DONE;
            error_d     = 1'b1;
            quotient_d  = '1;
            remainder_d = op_a;
          end else if (!is_div && ((op_a == '0) || (op_b == '0))) begin
            state_d   = DONE;
            error_d   = 1'b0;
            product_d = '0;
          end
`endif
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          if (is_div_q) begin
            rem_d             = div_borrow ? div_shift[SIZE-1:0] : div_diff[SIZE-1:0];
            acc_d[SIZE-1:0]   = {acc_q[SIZE-2:0], ~div_borrow};
          end else begin
            acc_d = {mul_sum, acc_q[SIZE-1:1]};
          end
          cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
          if (is_div_q) begin
            error_d     = bz_q;
            quotient_d  = bz_q ? {SIZE{1'b1}} : qr_fix[0];
            remainder_d = qr_fix[1];
          end else begin
            error_d   = 1'b0;
            product_d = prod_fix[0];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      bz_q        <= 1'b0;
      opnd_q      <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      product_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      bz_q        <= bz_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      rem_q       <= rem_d;
      product_q   <= product_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      error_q     <= error_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign valid     = (state_q == DONE);
  assign error     = error_q;
  assign product   = product_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_muldiv_nbit.sv
// Directed-vector bench for muldiv_nbit (SIZE=33), plus held-start, kill and
// mid-operation reset sequences.
module tb_muldiv_nbit;

  localparam int SIZE = 33;

  logic              clk = 1'b0;
  logic              reset, kill, start, is_div, is_signed;
  logic [SIZE-1:0]   op_a, op_b;
  logic              ready, valid, error;
  logic [2*SIZE-1:0] product;
  logic [SIZE-1:0]   quotient, remainder;

  muldiv_nbit #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .reset     (reset),
    .kill      (kill),
    .start     (start),
    .is_div    (is_div),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .ready     (ready),
    .valid     (valid),
    .error     (error),
    .product   (product),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        d;
    logic        s;
    logic [32:0] a;
    logic [32:0] b;
    logic [65:0] prod;
    logic [32:0] q;
    logic [32:0] r;
    logic        err;
  } vec_t;

  vec_t        vecs [13];
  int          total = 0;
  int          bad   = 0;
  int          vcount = 0;
  logic [65:0] m_prod;
  logic [32:0] m_q, m_r;

  always @(posedge clk) if (valid === 1'b1) vcount <= vcount + 1;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic d, input logic [32:0] a, input logic [32:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (d ? (b == '0) : ((a == '0) || (b == '0))) return 0;
`endif
    return SIZE + 1;
  endfunction

  // Drive one op, release start after the accept edge, return edges to valid.
  task automatic launch(input logic d, input logic s, input logic [32:0] a,
                        input logic [32:0] b, output int lat);
    is_div = d; is_signed = s; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int lat;
    chk("ready_before", 66'(ready), 66'(1'b1));
    launch(v.d, v.s, v.a, v.b, lat);
    $display("op %0d: div=%0b sgn=%0b a=%h b=%h -> prod=%h q=%h r=%h err=%0b edges=%0d",
             idx, v.d, v.s, v.a, v.b, product, quotient, remainder, error, lat);
    chk("latency", 66'(lat), 66'(exp_lat(v.d, v.a, v.b)));
    chk("error", 66'(error), 66'(v.err));
    if (v.d) begin
      chk("quotient", 66'(quotient), 66'(v.q));
      chk("remainder", 66'(remainder), 66'(v.r));
      chk("product_hold", product, m_prod);
      m_q = v.q; m_r = v.r;
    end else begin
      chk("product", product, v.prod);
      chk("quotient_hold", 66'(quotient), 66'(m_q));
      chk("remainder_hold", 66'(remainder), 66'(m_r));
      m_prod = v.prod;
    end
    @(posedge clk); #1;
    chk("valid_pulse", 66'(valid), 66'(1'b0));
    chk("ready_return", 66'(ready), 66'(1'b1));
  endtask

  initial begin
    int n;
    int vc0;
    vec_t v;

    //         div  sgn  a                b                product                      quotient         remainder        err
    vecs[0]  = '{1'b0, 1'b0, 33'd7,          33'd6,          66'd42,                      33'd0,           33'd0,           1'b0};
    vecs[1]  = '{1'b0, 1'b1, 33'h1_FFFF_FFFD, 33'd5,          66'h3_FFFF_FFFF_FFFF_FFF1,   33'd0,           33'd0,           1'b0};
    vecs[2]  = '{1'b1, 1'b1, 33'h1_FFFF_FFF9, 33'd2,          66'd0,                       33'h1_FFFF_FFFD, 33'h1_FFFF_FFFF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 33'd100,        33'd7,          66'd0,                       33'd14,          33'd2,           1'b0};
    vecs[4]  = '{1'b1, 1'b0, 33'd100,        33'd0,          66'd0,                       33'h1_FFFF_FFFF, 33'd100,         1'b1};
    vecs[5]  = '{1'b1, 1'b1, 33'h1_0000_0000, 33'h1_FFFF_FFFF, 66'd0,                      33'h1_0000_0000, 33'd0,           1'b0};
    vecs[6]  = '{1'b0, 1'b1, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 66'd1,                      33'd0,           33'd0,           1'b0};
    vecs[7]  = '{1'b0, 1'b0, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 66'h3_FFFF_FFFC_0000_0001,  33'd0,           33'd0,           1'b0};
    vecs[8]  = '{1'b0, 1'b0, 33'd0,          33'd12345,      66'd0,                       33'd0,           33'd0,           1'b0};
    vecs[9]  = '{1'b1, 1'b1, 33'd7,          33'h1_FFFF_FFFE, 66'd0,                      33'h1_FFFF_FFFD, 33'd1,           1'b0};
    vecs[10] = '{1'b1, 1'b1, 33'h1_FFFF_FFF9, 33'd0,          66'd0,                       33'h1_FFFF_FFFF, 33'h1_FFFF_FFF9, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 33'h1_FFFF_FFFF, 33'h1_0000_0000, 66'd0,                      33'd1,           33'h0_FFFF_FFFF, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 33'h1_0000_0000, 33'h1_FFFF_FFFF, 66'h0_0000_0001_0000_0000,  33'd0,           33'd0,           1'b0};

    reset = 1'b1; kill = 1'b0; start = 1'b0;
    is_div = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    m_prod = '0; m_q = '0; m_r = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", 66'(ready), 66'(1'b1));
    chk("rst_valid", 66'(valid), 66'(1'b0));
    chk("rst_error", 66'(error), 66'(1'b0));
    chk("rst_product", product, 66'd0);
    chk("rst_quotient", 66'(quotient), 66'd0);
    chk("rst_remainder", 66'(remainder), 66'd0);

    for (int i = 0; i < 13; i++) begin
      run_vec(i, vecs[i]);
    end

    // Held start plus an intruding start during CALC: exactly one result.
    vc0 = vcount;
    is_div = 1'b1; is_signed = 1'b0; op_a = 33'd100; op_b = 33'd7; start = 1'b1;
    @(posedge clk); #1;
    n = 0;
    repeat (2) begin @(posedge clk); #1; n++; end
    start = 1'b0;
    repeat (8) begin @(posedge clk); #1; n++; end
    is_div = 1'b0; op_a = 33'd1; op_b = 33'd1; start = 1'b1;
    @(posedge clk); #1; n++;
    start = 1'b0;
    while (valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
    $display("held-start: q=%h r=%h prod=%h edges=%0d", quotient, remainder, product, n);
    chk("held_latency", 66'(n), 66'(SIZE + 1));
    chk("held_quotient", 66'(quotient), 66'd14);
    chk("held_remainder", 66'(remainder), 66'd2);
    chk("held_product", product, m_prod);
    m_q = 33'd14; m_r = 33'd2;
    // Start presented in the DONE cycle must be ignored.
    is_div = 1'b1; op_a = 33'd5; op_b = 33'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_start_ready", 66'(ready), 66'(1'b1));
    @(posedge clk); #1;
    chk("done_start_idle", 66'(ready), 66'(1'b1));
    repeat (40) @(posedge clk);
    #1;
    $display("held-start: valid pulses=%0d", vcount - vc0);
    chk("held_one_valid", 66'(vcount - vc0), 66'd1);

    // kill on the tenth CALC cycle, then kill together with start in IDLE.
    vc0 = vcount;
    is_div = 1'b1; is_signed = 1'b0; op_a = 33'd1000; op_b = 33'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_ready", 66'(ready), 66'(1'b1));
    chk("kill_valid", 66'(valid), 66'(1'b0));
    kill = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0; start = 1'b0;
    chk("kill_start_ready", 66'(ready), 66'(1'b1));
    repeat (40) @(posedge clk);
    #1;
    $display("kill: valid pulses=%0d q=%h r=%h", vcount - vc0, quotient, remainder);
    chk("kill_no_valid", 66'(vcount - vc0), 66'd0);
    chk("kill_q_hold", 66'(quotient), 66'(m_q));
    chk("kill_r_hold", 66'(remainder), 66'(m_r));
    v = '{1'b1, 1'b0, 33'd1000, 33'd3, 66'd0, 33'd333, 33'd1, 1'b0};
    run_vec(13, v);

    // Reset in the middle of CALC clears all results.
    is_div = 1'b0; is_signed = 1'b0; op_a = 33'd9; op_b = 33'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    $display("mid-reset: ready=%0b valid=%0b prod=%h q=%h r=%h err=%0b",
             ready, valid, product, quotient, remainder, error);
    chk("mrst_ready", 66'(ready), 66'(1'b1));
    chk("mrst_valid", 66'(valid), 66'(1'b0));
    chk("mrst_error", 66'(error), 66'(1'b0));
    chk("mrst_product", product, 66'd0);
    chk("mrst_quotient", 66'(quotient), 66'd0);
    chk("mrst_remainder", 66'(remainder), 66'd0);
    m_prod = '0; m_q = '0; m_r = '0;
    v = '{1'b0, 1'b0, 33'd9, 33'd9, 66'd81, 33'd0, 33'd0, 1'b0};
    run_vec(14, v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
